// File: rtl/pcileech_tlp_rx_packer_if.sv
// Bus bundle between the PCIe core RX stream, the packer and the TLP consumer.
// Valid/ready: a beat moves on a rising edge where rx_valid & rx_ready; the consumer pulls with tlp_req_data while tlp_has_data.
interface pcileech_tlp_rx_packer_if;
  logic [63:0]   rx_data;
  logic [7:0]    rx_keep;
  logic          rx_last;
  logic          rx_valid;
  logic          rx_ready;
  logic [1187:0] tlp_data;
  logic          tlp_valid;
  logic          tlp_has_data;
  logic          tlp_req_data;
  logic [15:0]   drop_cnt;

  modport slave (
    input  rx_data, rx_keep, rx_last, rx_valid, tlp_req_data,
    output rx_ready, tlp_data, tlp_valid, tlp_has_data, drop_cnt
  );

  modport master (
    output rx_data, rx_keep, rx_last, rx_valid, tlp_req_data,
    input  rx_ready, tlp_data, tlp_valid, tlp_has_data, drop_cnt
  );
endinterface

// File: rtl/pcileech_tlp_rx_packer.sv
// Packs up to 18 64-bit RX beats of one TLP into a 1188-bit word (66-bit slots)
// and hands it out through a has_data/req_data/valid pull handshake.
module pcileech_tlp_rx_packer (
  input  logic                      clk,
  input  logic                      rst_n,
  pcileech_tlp_rx_packer_if.slave   bus,
  output logic [1:0]                fsm_state
);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } state_t;

  localparam logic [4:0] LAST_SLOT = 5'd17;

  state_t          state;
  logic [4:0]      idx;
  logic [1187:0]   asm_q;
  logic [1187:0]   out_q;
  logic            out_full;
  logic            valid_q;
  logic [15:0]     drop_q;
  logic [10:0]     slot_base;
  logic            accept;

  // Ready is gated by reset so the core never sees a ready beat while we are held.
  assign bus.rx_ready     = rst_n & (state != S_HOLD);
  assign accept           = bus.rx_valid & bus.rx_ready;
  assign slot_base        = 11'(idx) * 11'd66;

  assign bus.tlp_data     = out_q;
  assign bus.tlp_valid    = valid_q;
  assign bus.tlp_has_data = out_full;
  assign bus.drop_cnt     = drop_q;
  assign fsm_state        = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FILL;
      idx      <= '0;
      asm_q    <= '0;
      out_q    <= '0;
      out_full <= 1'b0;
      valid_q  <= 1'b0;
      drop_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      if (out_full && bus.tlp_req_data) begin
        valid_q  <= 1'b1;
        out_full <= 1'b0;
      end

      case (state)
        S_FILL: begin
          if (accept) begin
            asm_q[slot_base +: 66] <= {bus.rx_keep[4], bus.rx_last, bus.rx_data};
            if (bus.rx_last) begin
              state <= S_HOLD;
            end else if (idx == LAST_SLOT) begin
              // Oversize: forget what was assembled and swallow the rest of the TLP.
              asm_q <= '0;
              idx   <= '0;
              if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
              state <= S_DROP;
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end

        S_HOLD: begin
          // Waiting on valid_q keeps out stable for the whole delivery cycle.
          if (!out_full && !valid_q) begin
            out_q    <= asm_q;
            out_full <= 1'b1;
            asm_q    <= '0;
            idx      <= '0;
            state    <= S_FILL;
          end
        end

        S_DROP: begin
          if (accept && bus.rx_last) state <= S_FILL;
        end

        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_pcileech_tlp_rx_packer.sv
// Directed bench for pcileech_tlp_rx_packer: vector table of beats plus hand-written
// sequences for max-size, oversize, backpressure, async reset and spurious pulls.
module tb_pcileech_tlp_rx_packer;

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;

  logic       clk;
  logic       rst_n;
  logic [1:0] fsm_state;

  pcileech_tlp_rx_packer_if bus();

  pcileech_tlp_rx_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [1187:0] exp_q[$];

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        exp_keep;
    logic        exp_last;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [1187:0] act, input logic [1187:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      for (int i = 0; i < 18; i++) begin
        if (act[66*i +: 66] !== exp[66*i +: 66]) begin
          $display("FAIL %s slot %0d: got %h expected %h", name, i, act[66*i +: 66], exp[66*i +: 66]);
          break;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [63:0] data, input logic [7:0] keep, input logic last);
    int waited;
    @(negedge clk);
    bus.rx_data  = data;
    bus.rx_keep  = keep;
    bus.rx_last  = last;
    bus.rx_valid = 1'b1;
    waited = 0;
    while (!bus.rx_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.rx_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_beat timeout: rx_ready got 0 expected 1");
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_has_data(input string name);
    int waited;
    waited = 0;
    while (!bus.tlp_has_data && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check({name, " has_data wait"}, 66'(bus.tlp_has_data), 66'd1);
  endtask

  task automatic pull_check(input string name);
    logic [1187:0] exp_w;
    @(negedge clk);
    bus.tlp_req_data = 1'b1;
    @(posedge clk);
    #1;
    bus.tlp_req_data = 1'b0;
    check({name, " valid"}, 66'(bus.tlp_valid), 66'd1);
    check({name, " has_data low"}, 66'(bus.tlp_has_data), 66'd0);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got a delivery expected none queued", name);
    end else begin
      exp_w = exp_q.pop_front();
      check_word({name, " data"}, bus.tlp_data, exp_w);
    end
    @(posedge clk);
    #1;
    check({name, " valid one cycle"}, 66'(bus.tlp_valid), 66'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [1187:0] w;
    int slot;
    logic [63:0] d;

    vecs[0] = '{64'h0000_000F_0000_0001, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{64'h0000_0000_1234_5678, 8'h0F, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{64'hDEAD_BEEF_4A00_0002, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{64'h1111_2222_3333_4444, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{64'h5555_6666_7777_8888, 8'hFF, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{64'h0123_4567_89AB_CDEF, 8'h0F, 1'b1, 1'b0, 1'b1};

    bus.rx_data      = '0;
    bus.rx_keep      = '0;
    bus.rx_last      = 1'b0;
    bus.rx_valid     = 1'b0;
    bus.tlp_req_data = 1'b0;
    rst_n            = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset rx_ready", 66'(bus.rx_ready), 66'd0);
    check("reset has_data", 66'(bus.tlp_has_data), 66'd0);
    check("reset valid", 66'(bus.tlp_valid), 66'd0);
    check("reset drop_cnt", 66'(bus.drop_cnt), 66'd0);
    check_word("reset tlp_data", bus.tlp_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post reset rx_ready", 66'(bus.rx_ready), 66'd1);
    check("post reset state", 66'(fsm_state), 66'(ST_FILL));

    // Table-driven TLPs: 2-beat MRd, 3-beat, 1-beat.
    w = '0;
    slot = 0;
    for (int v = 0; v < 6; v++) begin
      send_beat(vecs[v].data, vecs[v].keep, vecs[v].last);
      w[66*slot +: 66] = {vecs[v].exp_keep, vecs[v].exp_last, vecs[v].data};
      slot++;
      if (vecs[v].last) begin
        exp_q.push_back(w);
        w = '0;
        slot = 0;
        check($sformatf("vec%0d hold rx_ready", v), 66'(bus.rx_ready), 66'd0);
        check($sformatf("vec%0d hold state", v), 66'(fsm_state), 66'(ST_HOLD));
        check($sformatf("vec%0d has_data early", v), 66'(bus.tlp_has_data), 66'd0);
        @(posedge clk);
        #1;
        check($sformatf("vec%0d has_data k+1", v), 66'(bus.tlp_has_data), 66'd1);
        check($sformatf("vec%0d rx_ready k+1", v), 66'(bus.rx_ready), 66'd1);
        pull_check($sformatf("vec%0d pull", v));
      end
    end

    // Maximum legal TLP: 18 beats, last on beat 18.
    w = '0;
    for (int i = 0; i < 18; i++) begin
      d = {32'hAB00_0000 + 32'(i), 32'h0000_CD00 + 32'(i)};
      send_beat(d, (i == 17) ? 8'h0F : 8'hFF, i == 17);
      w[66*i +: 66] = {(i != 17), (i == 17), d};
    end
    exp_q.push_back(w);
    wait_has_data("max18");
    check("max18 drop_cnt", 66'(bus.drop_cnt), 66'd0);
    pull_check("max18 pull");

    // Oversize: 20 beats, dropped and counted.
    for (int i = 0; i < 20; i++) begin
      send_beat({32'hEEEE_0000 + 32'(i), 32'h0000_FFFF}, 8'hFF, i == 19);
    end
    repeat (3) @(posedge clk);
    #1;
    check("oversize has_data", 66'(bus.tlp_has_data), 66'd0);
    check("oversize drop_cnt", 66'(bus.drop_cnt), 66'd1);
    check("oversize state", 66'(fsm_state), 66'(ST_FILL));
    send_beat(64'h7777_0000_0000_0001, 8'hFF, 1'b0);
    send_beat(64'h8888_0000_0000_0002, 8'h0F, 1'b1);
    w = '0;
    w[65:0]   = {1'b1, 1'b0, 64'h7777_0000_0000_0001};
    w[131:66] = {1'b0, 1'b1, 64'h8888_0000_0000_0002};
    exp_q.push_back(w);
    wait_has_data("after drop");
    pull_check("after drop pull");

    // Backpressure: two TLPs with no pull; the second stalls in HOLD.
    send_beat(64'h0A0A_0A0A_0B0B_0B0B, 8'hFF, 1'b1);
    w = '0;
    w[65:0] = {1'b1, 1'b1, 64'h0A0A_0A0A_0B0B_0B0B};
    exp_q.push_back(w);
    send_beat(64'h0C0C_0C0C_0D0D_0D0D, 8'hFF, 1'b0);
    send_beat(64'h0E0E_0E0E_0F0F_0F0F, 8'h0F, 1'b1);
    w = '0;
    w[65:0]   = {1'b1, 1'b0, 64'h0C0C_0C0C_0D0D_0D0D};
    w[131:66] = {1'b0, 1'b1, 64'h0E0E_0E0E_0F0F_0F0F};
    exp_q.push_back(w);
    repeat (4) @(posedge clk);
    #1;
    check("bp stall rx_ready", 66'(bus.rx_ready), 66'd0);
    check("bp stall state", 66'(fsm_state), 66'(ST_HOLD));
    check("bp stall has_data", 66'(bus.tlp_has_data), 66'd1);
    pull_check("bp first pull");
    check("bp p+1 has_data", 66'(bus.tlp_has_data), 66'd0);
    check("bp p+1 rx_ready", 66'(bus.rx_ready), 66'd0);
    @(posedge clk);
    #1;
    check("bp p+2 has_data", 66'(bus.tlp_has_data), 66'd1);
    check("bp p+2 rx_ready", 66'(bus.rx_ready), 66'd1);
    pull_check("bp second pull");

    // Async reset in the middle of beat 3 of a 5-beat TLP.
    send_beat(64'h9999_0000_0000_0001, 8'hFF, 1'b0);
    send_beat(64'h9999_0000_0000_0002, 8'hFF, 1'b0);
    @(negedge clk);
    bus.rx_data  = 64'h9999_0000_0000_0003;
    bus.rx_keep  = 8'hFF;
    bus.rx_last  = 1'b0;
    bus.rx_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("areset rx_ready", 66'(bus.rx_ready), 66'd0);
    check("areset has_data", 66'(bus.tlp_has_data), 66'd0);
    check("areset valid", 66'(bus.tlp_valid), 66'd0);
    check("areset drop_cnt", 66'(bus.drop_cnt), 66'd0);
    check_word("areset tlp_data", bus.tlp_data, '0);
    bus.rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(64'hCAFE_F00D_1234_0001, 8'hFF, 1'b1);
    w = '0;
    w[65:0] = {1'b1, 1'b1, 64'hCAFE_F00D_1234_0001};
    exp_q.push_back(w);
    wait_has_data("after reset");
    pull_check("after reset pull");

    // Spurious pull requests with nothing waiting.
    @(negedge clk);
    bus.tlp_req_data = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("spurious valid %0d", i), 66'(bus.tlp_valid), 66'd0);
    end
    bus.tlp_req_data = 1'b0;
    check("spurious has_data", 66'(bus.tlp_has_data), 66'd0);

    check("scoreboard drained", 66'(exp_q.size()), 66'd0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
